cache_mem_arbiter: RTL
======================

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 Parameter: BEATS, 4, beats per cache-line burst.
REQ-002 Parameter: BEAT_W, 64, memory data width in bits; line width = BEATS*BEAT_W = 256.
REQ-003 clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-004 i_req  in  1  icache request pending (level, request-stage indicator, independent of i_ready).
REQ-005 i_ready  out  1  icache may issue its read command this cycle.
REQ-006 i_read  in  1  icache read command, valid only when i_ready.
REQ-007 i_addr  in  32  icache line address, bits [4:0] zero.
REQ-008 i_rvalid/i_rdata/i_raddr  out  1/BEAT_W/32  forwarded read beat to icache.
REQ-009 d_req, d_ready, d_read, d_addr, d_rvalid, d_rdata, d_raddr: dcache equivalents of REQ-004..008.
REQ-010 d_write  in  1  dcache writeback command, valid only when d_ready; d_wdata  in  256  line data; d_wdone  out  1  writeback complete pulse.
REQ-011 mem_ready  in  1; mem_read, mem_write  out  1; mem_addr  out  32; mem_wdata  out  BEAT_W.
REQ-012 mem_rvalid  in  1; mem_rdata  in  BEAT_W; mem_raddr  in  32  burst base address of returning beat.

Function
REQ-013 FSM states SHALL be IDLE, RD_WAIT, WR_BURST.
REQ-014 In IDLE with mem_ready=1, exactly one ready SHALL assert, to the arbitration winner among asserted i_req/d_req; none when no req or mem_ready=0.
REQ-015 x_ready SHALL be combinational from state, mem_ready, i_req, d_req, grant pointer only, never from i_read/d_read/d_write.
REQ-016 Command cycle (x_ready & (x_read|x_write)): mem_addr=x_addr, mem_read or mem_write=1 same cycle; owner latched; state -> RD_WAIT (read) or WR_BURST (write).
REQ-017 x_read/x_write without x_ready SHALL be ignored; d_read and d_write together SHALL be treated as write.
REQ-018 RD_WAIT: each mem_rvalid beat SHALL be forwarded combinationally (rvalid, rdata, raddr) to owner only; non-owner rvalid=0; 2-bit beat counter increments per beat.
REQ-019 RD_WAIT SHALL exit to IDLE after beat BEATS-1; a new grant is possible the following cycle.
REQ-020 mem_rvalid while IDLE or WR_BURST SHALL be dropped (no rvalid to either cache).
REQ-021 Write: d_wdata latched at command; beat k = d_wdata[k*64 +: 64]; beat 0 on command cycle, beats 1..3 on next three cycles, mem_write=1 and mem_addr constant for all four.
REQ-022 d_wdone SHALL pulse one cycle, coincident with beat 3; state -> IDLE next cycle.
REQ-023 mem_ready is sampled only in IDLE; write beats advance unconditionally.
REQ-024 Grant pointer updates only on command cycles; requests in non-IDLE states wait.

Reset
REQ-025 On rst: state IDLE, beat counter 0, owner none, grant pointer = icache-last.
REQ-026 While/after rst: i_ready, d_ready, mem_read, mem_write, i_rvalid, d_rvalid, d_wdone = 0; mem_addr, mem_wdata = 0.
REQ-027 Reset mid-burst SHALL abandon the burst; subsequent stray beats handled per REQ-020.

Configuration
REQ-028 Macro ARB_RR_EN defined: round-robin; on tie, winner = requester not granted last; after reset dcache wins first tie.
REQ-029 ARB_RR_EN undefined: fixed priority, dcache always wins tie; grant pointer logic absent.

Verification
REQ-030 Single icache read 0x0000_1040, mem returns 4 beats 0xA0..0xA3 with gaps -> i_rvalid x4 in order, d_rvalid=0, IDLE after beat 3.
REQ-031 i_req,d_req same cycle with ARB_RR_EN -> d first, then i, then d again on repeated tie; without macro -> d every tie.
REQ-032 d_write 0x0000_2000, d_wdata beats 0x11..0x44 -> mem_write 4 consecutive cycles, mem_wdata 0x11,0x22,0x33,0x44, d_wdone on 4th.
REQ-033 mem_ready=0 for 5 cycles with i_req=1 -> i_ready=0 throughout, grant cycle after mem_ready rises.
REQ-034 rst asserted after beat 1 of icache read -> beats 2,3 dropped, i_ready available next IDLE cycle.
REQ-035 mem_rvalid pulse in IDLE -> no rvalid on either port.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
// Arbitrates a single burst memory port between an icache (reads only) and a
// dcache (reads and line writebacks).
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   i_req/i_ready/i_read/i_addr icache request level, grant, read command, line address
//   i_rvalid/i_rdata/i_raddr   read beats forwarded to the icache
//   d_req/d_ready/d_read/d_addr dcache equivalents
//   d_write/d_wdata/d_wdone    dcache writeback command, line data, completion pulse
//   d_rvalid/d_rdata/d_raddr   read beats forwarded to the dcache
//   mem_ready/mem_read/mem_write/mem_addr/mem_wdata  memory command side
//   mem_rvalid/mem_rdata/mem_raddr                   memory read-return side
//
// Build option:
//   ARB_RR_EN  defined   -> round-robin on a tie (dcache wins the first tie after reset)
//              undefined -> fixed priority, dcache always wins a tie
//
// BEATS must be a power of two and at least 2.

module cache_mem_arbiter #(
    parameter int BEATS  = 4,
    parameter int BEAT_W = 64
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    i_req,
    output logic                    i_ready,
    input  logic                    i_read,
    input  logic [31:0]             i_addr,
    output logic                    i_rvalid,
    output logic [BEAT_W-1:0]       i_rdata,
    output logic [31:0]             i_raddr,

    input  logic                    d_req,
    output logic                    d_ready,
    input  logic                    d_read,
    input  logic                    d_write,
    input  logic [31:0]             d_addr,
    input  logic [BEATS*BEAT_W-1:0] d_wdata,
    output logic                    d_wdone,
    output logic                    d_rvalid,
    output logic [BEAT_W-1:0]       d_rdata,
    output logic [31:0]             d_raddr,

    input  logic                    mem_ready,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [31:0]             mem_addr,
    output logic [BEAT_W-1:0]       mem_wdata,
    input  logic                    mem_rvalid,
    input  logic [BEAT_W-1:0]       mem_rdata,
    input  logic [31:0]             mem_raddr
);

    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_BURST} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

    state_t                   state, state_n;
    owner_t                   owner, owner_n;
    logic [CNT_W-1:0]         cnt, cnt_n;
    logic [BEATS*BEAT_W-1:0]  wbuf, wbuf_n;
    logic [31:0]              waddr, waddr_n;
    logic                     i_win, d_win;

`ifdef ARB_RR_EN
    // last_d = 1 when the dcache holds the most recent grant; reset value
    // means "icache last", so the dcache takes the first tie.
    logic last_d, last_d_n;

    always_comb begin
        i_win = i_req & (~d_req | last_d);
        d_win = d_req & (~i_req | ~last_d);
    end

    // Pointer moves only when a command is actually accepted.
    always_comb begin
        last_d_n = last_d;
        if (state == IDLE && (mem_read || mem_write))
            last_d_n = (owner_n == OWN_D);
    end

    always_ff @(posedge clk) begin
        if (rst) last_d <= 1'b0;
        else     last_d <= last_d_n;
    end
`else
    always_comb begin
        d_win = d_req;
        i_win = i_req & ~d_req;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= OWN_NONE;
            cnt   <= '0;
            wbuf  <= '0;
            waddr <= '0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            cnt   <= cnt_n;
            wbuf  <= wbuf_n;
            waddr <= waddr_n;
        end
    end

    always_comb begin
        state_n   = state;
        owner_n   = owner;
        cnt_n     = cnt;
        wbuf_n    = wbuf;
        waddr_n   = waddr;
        i_ready   = 1'b0;
        d_ready   = 1'b0;
        i_rvalid  = 1'b0;
        d_rvalid  = 1'b0;
        d_wdone   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        // Data and address paths are shared; only the valids are steered.
        i_rdata   = mem_rdata;
        d_rdata   = mem_rdata;
        i_raddr   = mem_raddr;
        d_raddr   = mem_raddr;

        case (state)
            IDLE: begin
                // Readiness never looks at the command inputs, so a cache may
                // wait for ready before deciding to issue.
                i_ready = ~rst & mem_ready & i_win;
                d_ready = ~rst & mem_ready & d_win;
                if (d_ready && d_write) begin
                    // Write wins over a simultaneous d_read. Beat 0 goes out now.
                    mem_write = 1'b1;
                    mem_addr  = d_addr;
                    mem_wdata = d_wdata[BEAT_W-1:0];
                    wbuf_n    = d_wdata;
                    waddr_n   = d_addr;
                    cnt_n     = CNT_W'(1);
                    owner_n   = OWN_D;
                    state_n   = WR_BURST;
                end else if (d_ready && d_read) begin
                    mem_read = 1'b1;
                    mem_addr = d_addr;
                    cnt_n    = '0;
                    owner_n  = OWN_D;
                    state_n  = RD_WAIT;
                end else if (i_ready && i_read) begin
                    mem_read = 1'b1;
                    mem_addr = i_addr;
                    cnt_n    = '0;
                    owner_n  = OWN_I;
                    state_n  = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (mem_rvalid) begin
                    i_rvalid = (owner == OWN_I);
                    d_rvalid = (owner == OWN_D);
                    cnt_n    = cnt + 1'b1;
                    if (cnt == LAST_BEAT) begin
                        cnt_n   = '0;
                        owner_n = OWN_NONE;
                        state_n = IDLE;
                    end
                end
            end
            WR_BURST: begin
                // Memory must accept the remaining beats back to back.
                mem_write = 1'b1;
                mem_addr  = waddr;
                mem_wdata = wbuf[int'(cnt)*BEAT_W +: BEAT_W];
                cnt_n     = cnt + 1'b1;
                if (cnt == LAST_BEAT) begin
                    d_wdone = 1'b1;
                    cnt_n   = '0;
                    owner_n = OWN_NONE;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // Hold every command/strobe quiet while reset is asserted.
        if (rst) begin
            i_ready   = 1'b0;
            d_ready   = 1'b0;
            i_rvalid  = 1'b0;
            d_rvalid  = 1'b0;
            d_wdone   = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

endmodule
